// File: rtl/stripe_scheduler_pkg.sv
// Shared sizing, score width and FSM state encoding for the stripe scheduler.
package stripe_scheduler_pkg;

   localparam int PE_NUM     = 64;
   localparam int SEQ_LEN    = 1024;
   localparam int GAP        = 4;
   localparam int STRIPE_NUM = SEQ_LEN / PE_NUM;
   localparam int SCORE_W    = 14;
   localparam int STRIPE_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_B,
      GAP_WAIT,
      STREAM,
      PAD,
      DONE
   } state_t;

endpackage

// File: rtl/stripe_scheduler_max_tracker.sv
// Running maximum of per-stripe scores, registered one cycle after i_update.
// Strict compare keeps the earliest stripe on ties; accepts an update every cycle.
module max_tracker
   import stripe_scheduler_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clear,
   input  logic                i_update,
   input  logic [SCORE_W-1:0]  i_score,
   input  logic [STRIPE_W-1:0] i_stripe,
   output logic [SCORE_W-1:0]  o_max_score,
   output logic [STRIPE_W-1:0] o_max_stripe
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_max_score  <= '0;
         o_max_stripe <= '0;
      end else if (i_clear) begin
         o_max_score  <= '0;
         o_max_stripe <= '0;
      end else if (i_update && (i_score > o_max_score)) begin
         o_max_score  <= i_score;
         o_max_stripe <= i_stripe;
      end
   end

endmodule

// File: rtl/stripe_scheduler.sv
// Walks B stripe by stripe: fetch B word, idle GAP cycles, stream A one base/cycle, pad until the PE array ends the stripe.
// B/A memories have one-cycle read latency; the PE array paces each stripe through i_stripe_end.
module stripe_scheduler #(
   parameter int PE_NUM  = stripe_scheduler_pkg::PE_NUM,
   parameter int SEQ_LEN = stripe_scheduler_pkg::SEQ_LEN,
   parameter int GAP     = stripe_scheduler_pkg::GAP
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_go,
   output logic [3:0]   o_B_addr,
   input  logic [127:0] i_B_data,
   output logic [9:0]   o_A_addr,
   input  logic [1:0]   i_A_data,
   output logic [127:0] o_B,
   output logic [1:0]   o_A,
   output logic         o_start,
   input  logic         i_stripe_end,
   input  logic [9:0]   i_start_position,
   input  logic [13:0]  i_max_score_stripe,
   output logic         o_busy,
   output logic         o_done,
   output logic [13:0]  o_max_score,
   output logic [3:0]   o_max_stripe
);

   import stripe_scheduler_pkg::*;

   localparam int          STRIPES = SEQ_LEN / PE_NUM;
   localparam int          GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [9:0]  A_LAST  = 10'(SEQ_LEN - 1);
   localparam logic [10:0] A_SAT   = 11'(SEQ_LEN - 1);
   localparam logic [3:0]  S_LAST  = 4'(STRIPES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       stripe_idx;
   logic [9:0]       a_start;
   logic [9:0]       a_addr;
   logic [9:0]       cur_idx;
   logic [9:0]       start_sat;
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_last;
   logic             b_phase;
   logic             run_init;
   logic             stripe_end_act;

   // a_addr runs one ahead of the base on o_A because memory data lags its address by a cycle.
   assign cur_idx   = a_addr - 10'd1;
   assign gap_last  = (gap_cnt == GAP_W'(GAP - 1));
   assign start_sat = ({1'b0, i_start_position} > A_SAT) ? A_LAST : i_start_position;

   assign o_B_addr = stripe_idx;
   assign o_A_addr = a_addr;
   assign o_A      = (state == STREAM) ? i_A_data : 2'b00;
   assign o_start  = (state == STREAM) || (state == PAD);
   assign o_busy   = (state != IDLE);
   assign o_done   = (state == DONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      run_init       = 1'b0;
      stripe_end_act = 1'b0;
      case (state)
         IDLE: begin
            if (i_go) begin
               run_init  = 1'b1;
               state_nxt = LOAD_B;
            end
         end
         LOAD_B: begin
            if (b_phase) begin
               state_nxt = GAP_WAIT;
            end
         end
         GAP_WAIT: begin
            if (gap_last) begin
               state_nxt = STREAM;
            end
         end
         STREAM, PAD: begin
            if (i_stripe_end) begin
               stripe_end_act = 1'b1;
               state_nxt      = (stripe_idx == S_LAST) ? DONE : LOAD_B;
            end else if ((state == STREAM) && (cur_idx == A_LAST)) begin
               state_nxt = PAD;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // LOAD_B spends one cycle on the address and latches the returned word on the second.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stripe_idx <= '0;
         a_start    <= '0;
         a_addr     <= '0;
         gap_cnt    <= '0;
         b_phase    <= 1'b0;
         o_B        <= '0;
      end else begin
         b_phase <= (state == LOAD_B) && !b_phase;
         gap_cnt <= (state == GAP_WAIT) ? gap_cnt + 1'b1 : '0;
         if (run_init) begin
            stripe_idx <= '0;
            a_start    <= '0;
         end
         if ((state == LOAD_B) && b_phase) begin
            o_B    <= i_B_data;
            a_addr <= a_start;
         end
         if (((state == GAP_WAIT) && gap_last) || (state == STREAM)) begin
            a_addr <= a_addr + 10'd1;
         end
         if (stripe_end_act) begin
            a_start <= start_sat;
            if (stripe_idx != S_LAST) begin
               stripe_idx <= stripe_idx + 4'd1;
            end
         end
      end
   end

   max_tracker u_max_tracker (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (run_init),
      .i_update     (stripe_end_act),
      .i_score      (i_max_score_stripe),
      .i_stripe     (stripe_idx),
      .o_max_score  (o_max_score),
      .o_max_stripe (o_max_stripe)
   );

endmodule

// File: tb/tb_stripe_scheduler.sv
// Bench for stripe_scheduler: a scenario table, a mid-stream reset sequence and randomized runs,
// all checked against a stripe-level model of which bases, B words and maxima each stripe should produce.
module tb_stripe_scheduler;

   localparam int PE_NUM     = 64;
   localparam int SEQ_LEN    = 1024;
   localparam int GAP        = 4;
   localparam int STRIPES    = SEQ_LEN / PE_NUM;
   localparam int LOW_CYCLES = GAP + 2;   // two B-fetch cycles precede the idle gap
   localparam int WAIT_MAX   = 40;

   typedef struct {
      int end_after;
      int pos;
      int s0;
      int s1;
      int s2;
      int srest;
      bit go_mid;
      bit noise;
      int exp_max;
      int exp_stripe;
   } vec_t;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_go = 1'b0;
   logic [3:0]   o_B_addr;
   logic [127:0] i_B_data = '0;
   logic [9:0]   o_A_addr;
   logic [1:0]   i_A_data = '0;
   logic [127:0] o_B;
   logic [1:0]   o_A;
   logic         o_start;
   logic         i_stripe_end = 1'b0;
   logic [9:0]   i_start_position = '0;
   logic [13:0]  i_max_score_stripe = '0;
   logic         o_busy;
   logic         o_done;
   logic [13:0]  o_max_score;
   logic [3:0]   o_max_stripe;

   logic [1:0]   a_mem [SEQ_LEN];
   logic [127:0] b_mem [STRIPES];
   int           run_end [STRIPES];
   int           run_pos [STRIPES];
   int           run_score [STRIPES];
   vec_t         tbl [5];

   int checks = 0;
   int errors = 0;
   int done_pulses = 0;

   stripe_scheduler #(
      .PE_NUM  (PE_NUM),
      .SEQ_LEN (SEQ_LEN),
      .GAP     (GAP)
   ) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_go               (i_go),
      .o_B_addr           (o_B_addr),
      .i_B_data           (i_B_data),
      .o_A_addr           (o_A_addr),
      .i_A_data           (i_A_data),
      .o_B                (o_B),
      .o_A                (o_A),
      .o_start            (o_start),
      .i_stripe_end       (i_stripe_end),
      .i_start_position   (i_start_position),
      .i_max_score_stripe (i_max_score_stripe),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_max_score        (o_max_score),
      .o_max_stripe       (o_max_stripe)
   );

   always #5 i_clk = ~i_clk;

   // Synchronous memories: data for an address appears one cycle later.
   always @(posedge i_clk) begin
      i_A_data <= a_mem[o_A_addr];
      i_B_data <= b_mem[o_B_addr];
   end

   always @(posedge i_clk) begin
      if (o_done) done_pulses++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      i_go = 1'b0;
      i_stripe_end = 1'b0;
      i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic wait_start(input string tag, output bit ok);
      int n = 0;
      while (!o_start && n < WAIT_MAX) begin
         n++;
         @(negedge i_clk);
      end
      ok = o_start;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s wait_start: o_start still 0 after %0d cycles, required within %0d", tag, n, WAIT_MAX);
      end
   endtask

   task automatic run_alignment(input string tag, input bit go_mid, input bit noise, output bit ok);
      int exp_start = 0;
      int exp_max = 0;
      int exp_idx = 0;
      int low;
      int bad;
      int moved;
      int idx;
      int pulses0;
      logic [1:0]   exp_a;
      logic [9:0]   pre_addr;
      logic [127:0] b_seen;
      ok = 1'b1;
      pulses0 = done_pulses;
      i_go = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      for (int s = 0; s < STRIPES; s++) begin
         low = 0;
         pre_addr = '0;
         while (!o_start && low < WAIT_MAX) begin
            pre_addr = o_A_addr;
            low++;
            i_stripe_end = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_go = go_mid && (s == 7) && (low == 3);
            @(negedge i_clk);
         end
         i_go = 1'b0;
         if (!o_start) begin
            checks++;
            errors++;
            $display("FAIL %s s%0d timeout: o_start low for %0d cycles, required %0d", tag, s, low, LOW_CYCLES);
            i_stripe_end = 1'b0;
            ok = 1'b0;
            return;
         end
         check($sformatf("%s s%0d low_cycles", tag, s), 128'(low), 128'(LOW_CYCLES));
         check($sformatf("%s s%0d prefetch_addr", tag, s), 128'(pre_addr), 128'(exp_start));
         check($sformatf("%s s%0d B_addr", tag, s), 128'(o_B_addr), 128'(s));
         check($sformatf("%s s%0d B_word", tag, s), o_B, b_mem[s]);
         b_seen = o_B;
         bad = 0;
         moved = 0;
         for (int k = 0; k < run_end[s]; k++) begin
            idx = exp_start + k;
            exp_a = 2'b00;
            if (idx < SEQ_LEN) exp_a = a_mem[idx];
            if (!o_start || (o_A !== exp_a)) bad++;
            if (o_B !== b_seen) moved++;
            if (k == run_end[s] - 1) begin
               i_stripe_end = 1'b1;
               i_start_position = 10'(run_pos[s]);
               i_max_score_stripe = 14'(run_score[s]);
            end else begin
               i_stripe_end = 1'b0;
               i_start_position = 10'($urandom);
               i_max_score_stripe = 14'($urandom);
            end
            @(negedge i_clk);
         end
         i_stripe_end = 1'b0;
         check($sformatf("%s s%0d bad_bases", tag, s), 128'(bad), 128'(0));
         check($sformatf("%s s%0d B_changes", tag, s), 128'(moved), 128'(0));
         check($sformatf("%s s%0d start_after_end", tag, s), 128'(o_start), 128'(0));
         if (run_score[s] > exp_max) begin
            exp_max = run_score[s];
            exp_idx = s;
         end
         exp_start = (run_pos[s] > SEQ_LEN - 1) ? SEQ_LEN - 1 : run_pos[s];
      end
      check($sformatf("%s done_pulse", tag), 128'(o_done), 128'(1));
      check($sformatf("%s busy_in_done", tag), 128'(o_busy), 128'(1));
      check($sformatf("%s max_score", tag), 128'(o_max_score), 128'(exp_max));
      check($sformatf("%s max_stripe", tag), 128'(o_max_stripe), 128'(exp_idx));
      @(negedge i_clk);
      check($sformatf("%s done_cleared", tag), 128'(o_done), 128'(0));
      check($sformatf("%s busy_after_done", tag), 128'(o_busy), 128'(0));
      repeat (2) @(negedge i_clk);
      check($sformatf("%s done_count", tag), 128'(done_pulses - pulses0), 128'(1));
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < SEQ_LEN; i++) a_mem[i] = 2'($urandom);
      for (int i = 0; i < STRIPES; i++) b_mem[i] = {$urandom, $urandom, $urandom, $urandom};

      //          end  pos   s0   s1   s2   rest   go  noise  max    stripe
      tbl[0] = '{100,  37,  50,  80,  80,    20, 1'b1, 1'b0,    80, 1};
      tbl[1] = '{ 12,   0,  10,  10,  10,    10, 1'b0, 1'b1,    10, 0};
      tbl[2] = '{  5, 512,   0,   0,   0,     0, 1'b0, 1'b0,     0, 0};
      tbl[3] = '{ 27, 1000,  5,   6,   7, 16383, 1'b0, 1'b1, 16383, 3};
      tbl[4] = '{ 40, 1023, 100, 50, 200,   199, 1'b1, 1'b1,   200, 2};

      repeat (3) @(negedge i_clk);
      check("reset o_start", 128'(o_start), 128'(0));
      check("reset o_busy", 128'(o_busy), 128'(0));
      check("reset o_done", 128'(o_done), 128'(0));
      check("reset o_B", o_B, 128'(0));
      check("reset o_A", 128'(o_A), 128'(0));
      check("reset o_max_score", 128'(o_max_score), 128'(0));
      check("reset o_max_stripe", 128'(o_max_stripe), 128'(0));
      check("reset o_B_addr", 128'(o_B_addr), 128'(0));
      check("reset o_A_addr", 128'(o_A_addr), 128'(0));
      i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);
      check("idle without go busy", 128'(o_busy), 128'(0));

      for (int v = 0; v < 5; v++) begin
         for (int s = 0; s < STRIPES; s++) begin
            run_end[s] = tbl[v].end_after;
            run_pos[s] = tbl[v].pos;
            run_score[s] = (s == 0) ? tbl[v].s0 : (s == 1) ? tbl[v].s1 : (s == 2) ? tbl[v].s2 : tbl[v].srest;
         end
         run_alignment($sformatf("vec%0d", v), tbl[v].go_mid, tbl[v].noise, ok);
         if (!ok) begin
            do_reset();
         end else begin
            check($sformatf("vec%0d held max_score", v), 128'(o_max_score), 128'(tbl[v].exp_max));
            check($sformatf("vec%0d held max_stripe", v), 128'(o_max_stripe), 128'(tbl[v].exp_stripe));
         end
      end

      // Reset while stripe 1 is streaming, after stripe 0 left a nonzero maximum.
      i_go = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      wait_start("mid_reset s0", ok);
      if (ok) begin
         for (int k = 0; k < 10; k++) begin
            i_stripe_end = (k == 9);
            i_max_score_stripe = 14'd77;
            i_start_position = 10'd5;
            @(negedge i_clk);
         end
         i_stripe_end = 1'b0;
         wait_start("mid_reset s1", ok);
         if (ok) begin
            repeat (3) @(negedge i_clk);
            check("mid_reset max_before", 128'(o_max_score), 128'(77));
            check("mid_reset start_before", 128'(o_start), 128'(1));
            i_rst_n = 1'b0;
            @(posedge i_clk);
            #1;
            check("mid_reset o_start", 128'(o_start), 128'(0));
            check("mid_reset o_busy", 128'(o_busy), 128'(0));
            check("mid_reset o_max_score", 128'(o_max_score), 128'(0));
            check("mid_reset o_B", o_B, 128'(0));
            check("mid_reset o_done", 128'(o_done), 128'(0));
            @(negedge i_clk);
            i_rst_n = 1'b1;
            repeat (10) @(negedge i_clk);
            check("after_reset idle busy", 128'(o_busy), 128'(0));
            check("after_reset idle start", 128'(o_start), 128'(0));
         end
      end
      do_reset();

      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < STRIPES; s++) begin
            run_end[s] = $urandom_range(1, 120);
            run_pos[s] = (r == 0) ? $urandom_range(SEQ_LEN - 60, SEQ_LEN - 1) : $urandom_range(0, SEQ_LEN - 1);
            run_score[s] = $urandom_range(0, 16383);
         end
         run_alignment($sformatf("rnd%0d", r), (r % 2) == 1, 1'b1, ok);
         if (!ok) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
